// File: rtl/gpio_cmd_regfile_mc.sv
// gpio_cmd_regfile_mc: multi-channel GPIO command register file.
// Decodes 32-bit command words (opcode[31:24], strobe[23], payload[22:0]) from the
// micro's GPIO and drives comm-system control: timed soft reset, RX enable,
// per-channel sigma, RAM logging / readback, atomic BER counter snapshots and a
// status word with sticky error flags.
// Optional build macro: REGF_AUTO_SNAPSHOT_EN adds a periodic automatic snapshot
// every AUTO_PERIOD cycles; without it snapshots come only from opcode 0x06.
module gpio_cmd_regfile_mc #(
    parameter int unsigned      NBT_GPIOS     = 32,
    parameter int unsigned      RAM_DEPTH     = 32768,
    parameter int unsigned      NBT_COUNT     = 64,
    parameter int unsigned      NCH           = 2,
    parameter logic signed [7:0] SIGMA_DEF    = 8'sh1C,
    parameter int unsigned      RST_PULSE_LEN = 16,
    parameter int unsigned      AUTO_PERIOD   = 1000000,
    localparam int unsigned     AW            = $clog2(RAM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic [NBT_GPIOS-1:0]     i_gpio_to_regf,
    input  logic [NCH*NBT_COUNT-1:0] i_accum_err,
    input  logic [NCH*NBT_COUNT-1:0] i_accum_bit,
    input  logic [31:0]              i_data_ram_for_read,
    output logic [31:0]              o_regf_to_gpio,
    output logic                     o_rst_soft,
    output logic                     o_en_rx_soft,
    output logic [NCH*8-1:0]         o_sigma,
    output logic [2:0]               o_data_sel_for_log,
    output logic                     o_en_write,
    output logic                     o_en_read_from_ram,
    output logic [AW-1:0]            o_read_adrs
);

    localparam int unsigned NW  = NBT_COUNT / 32;
    localparam int unsigned PCW = $clog2(RST_PULSE_LEN + 1);

    // Readback source select
    localparam logic [1:0] ModeNone   = 2'd0;
    localparam logic [1:0] ModeRam    = 2'd1;
    localparam logic [1:0] ModeCnt    = 2'd2;
    localparam logic [1:0] ModeStatus = 2'd3;

    logic [7:0]  opcode;
    logic [22:0] payload;
    logic        accept;
    logic        snap_cmd;
    logic        snap_take;

    logic                     stb_q;
    logic [PCW-1:0]           pulse_q, pulse_d;
    logic                     en_rx_q, en_rx_d;
    logic [7:0]               sigma_q [NCH];
    logic [7:0]               sigma_d [NCH];
    logic [2:0]               sel_log_q, sel_log_d;
    logic                     en_write_q, en_write_d;
    logic                     en_read_q, en_read_d;
    logic [AW-1:0]            adrs_q, adrs_d;
    logic [1:0]               rd_mode_q, rd_mode_d;
    logic [NCH*NBT_COUNT-1:0] snap_err_q, snap_err_d;
    logic [NCH*NBT_COUNT-1:0] snap_bit_q, snap_bit_d;
    logic [3:0]               sel_ch_q, sel_ch_d;
    logic                     sel_kind_q, sel_kind_d;
    logic [2:0]               sel_word_q, sel_word_d;
    logic                     err_op_q, err_op_d;
    logic                     err_sel_q, err_sel_d;
    logic                     err_ch_q, err_ch_d;
    logic [15:0]              cmd_count_q, cmd_count_d;
    logic [7:0]               last_op_q, last_op_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [31:0]              cnt_word;

    // Only part of the payload is decoded by any one opcode
    logic unused_gpio;
    assign unused_gpio = ^i_gpio_to_regf;

    assign opcode  = i_gpio_to_regf[31:24];
    assign payload = i_gpio_to_regf[22:0];
    // Rising edge of the strobe bit: a held strobe executes exactly once
    assign accept  = i_gpio_to_regf[23] & ~stb_q;

`ifdef REGF_AUTO_SNAPSHOT_EN
    localparam int unsigned ACW = $clog2(AUTO_PERIOD + 1);

    logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
    logic           auto_fire;

    assign auto_fire  = (auto_cnt_q == ACW'(AUTO_PERIOD - 1));
    // Coincident auto and command snapshots collapse into one
    assign snap_take  = snap_cmd | auto_fire;
    assign auto_cnt_d = snap_take ? '0 : auto_cnt_q + ACW'(1);

    // Free-running auto-snapshot period counter
    always_ff @(posedge clk) begin
        if (i_reset) auto_cnt_q <= '0;
        else         auto_cnt_q <= auto_cnt_d;
    end
`else
    localparam int unsigned unused_auto_period = AUTO_PERIOD;
    assign snap_take = snap_cmd;
`endif

    // Command decode and next-state for all control registers
    always_comb begin
        pulse_d     = (pulse_q != '0) ? pulse_q - PCW'(1) : '0;
        en_rx_d     = en_rx_q;
        sigma_d     = sigma_q;
        sel_log_d   = sel_log_q;
        en_write_d  = en_write_q;
        en_read_d   = en_read_q;
        adrs_d      = adrs_q;
        rd_mode_d   = rd_mode_q;
        sel_ch_d    = sel_ch_q;
        sel_kind_d  = sel_kind_q;
        sel_word_d  = sel_word_q;
        err_op_d    = err_op_q;
        err_sel_d   = err_sel_q;
        err_ch_d    = err_ch_q;
        cmd_count_d = cmd_count_q;
        last_op_d   = last_op_q;
        snap_cmd    = 1'b0;
        if (accept) begin
            cmd_count_d = cmd_count_q + 16'd1;
            last_op_d   = opcode;
            case (opcode)
                8'h01: if (payload[0]) pulse_d = PCW'(RST_PULSE_LEN);
                8'h02: en_rx_d = payload[0];
                8'h03: begin
                    for (int c = 0; c < NCH; c++) begin
                        if (payload[19:16] == 4'(c)) sigma_d[c] = payload[7:0];
                    end
                    if (32'(payload[19:16]) >= NCH) err_ch_d = 1'b1;
                end
                8'h04: begin
                    sel_log_d  = payload[2:0];
                    en_write_d = payload[3];
                end
                8'h05: begin
                    adrs_d    = payload[AW-1:0];
                    en_read_d = payload[16];
                    rd_mode_d = payload[16] ? ModeRam : ModeNone;
                end
                8'h06: snap_cmd = payload[0];
                8'h07: begin
                    sel_ch_d   = payload[7:4];
                    sel_kind_d = payload[3];
                    sel_word_d = payload[2:0];
                    rd_mode_d  = ModeCnt;
                    if (32'(payload[7:4]) >= NCH || 32'(payload[2:0]) >= NW) err_sel_d = 1'b1;
                end
                8'h08: begin
                    rd_mode_d = ModeStatus;
                    if (payload[0]) begin
                        err_op_d  = 1'b0;
                        err_sel_d = 1'b0;
                        err_ch_d  = 1'b0;
                    end
                end
                default: err_op_d = 1'b1;
            endcase
        end
    end

    // All channels are captured on the same edge so err/bit pairs stay coherent
    always_comb begin
        snap_err_d = snap_take ? i_accum_err : snap_err_q;
        snap_bit_d = snap_take ? i_accum_bit : snap_bit_q;
    end

    // Selected snapshot word; an out-of-range channel or word matches nothing and reads 0
    always_comb begin
        cnt_word = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int w = 0; w < NW; w++) begin
                if (sel_ch_q == 4'(c) && sel_word_q == 3'(w)) begin
                    cnt_word = sel_kind_q ? snap_bit_q[c*NBT_COUNT + 32*w +: 32]
                                          : snap_err_q[c*NBT_COUNT + 32*w +: 32];
                end
            end
        end
    end

    // Readback mux, registered every cycle
    always_comb begin
        rdata_d = '0;
        case (rd_mode_q)
            ModeRam:    rdata_d = i_data_ram_for_read;
            ModeCnt:    rdata_d = cnt_word;
            ModeStatus: rdata_d = {cmd_count_q, last_op_q, 5'b0, err_op_q, err_sel_q, err_ch_q};
            default:    rdata_d = '0;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_reset) begin
            stb_q       <= 1'b0;
            pulse_q     <= PCW'(RST_PULSE_LEN);
            en_rx_q     <= 1'b1;
            for (int c = 0; c < NCH; c++) sigma_q[c] <= SIGMA_DEF;
            sel_log_q   <= '0;
            en_write_q  <= 1'b0;
            en_read_q   <= 1'b0;
            adrs_q      <= '0;
            rd_mode_q   <= ModeNone;
            snap_err_q  <= '0;
            snap_bit_q  <= '0;
            sel_ch_q    <= '0;
            sel_kind_q  <= 1'b0;
            sel_word_q  <= '0;
            err_op_q    <= 1'b0;
            err_sel_q   <= 1'b0;
            err_ch_q    <= 1'b0;
            cmd_count_q <= '0;
            last_op_q   <= '0;
            rdata_q     <= '0;
        end else begin
            stb_q       <= i_gpio_to_regf[23];
            pulse_q     <= pulse_d;
            en_rx_q     <= en_rx_d;
            sigma_q     <= sigma_d;
            sel_log_q   <= sel_log_d;
            en_write_q  <= en_write_d;
            en_read_q   <= en_read_d;
            adrs_q      <= adrs_d;
            rd_mode_q   <= rd_mode_d;
            snap_err_q  <= snap_err_d;
            snap_bit_q  <= snap_bit_d;
            sel_ch_q    <= sel_ch_d;
            sel_kind_q  <= sel_kind_d;
            sel_word_q  <= sel_word_d;
            err_op_q    <= err_op_d;
            err_sel_q   <= err_sel_d;
            err_ch_q    <= err_ch_d;
            cmd_count_q <= cmd_count_d;
            last_op_q   <= last_op_d;
            rdata_q     <= rdata_d;
        end
    end

    // Output packing
    always_comb begin
        o_sigma = '0;
        for (int c = 0; c < NCH; c++) o_sigma[c*8 +: 8] = sigma_q[c];
    end

    assign o_rst_soft         = (pulse_q != '0);
    assign o_en_rx_soft       = en_rx_q;
    assign o_data_sel_for_log = sel_log_q;
    assign o_en_write         = en_write_q;
    assign o_en_read_from_ram = en_read_q;
    assign o_read_adrs        = adrs_q;
    assign o_regf_to_gpio     = rdata_q;

endmodule

// File: tb/tb_gpio_cmd_regfile_mc.sv
// Directed bench for gpio_cmd_regfile_mc (NCH=2, NBT_COUNT=64, RST_PULSE_LEN=16).
module tb_gpio_cmd_regfile_mc;

    logic         clk;
    logic         i_reset;
    logic [31:0]  i_gpio_to_regf;
    logic [127:0] i_accum_err;
    logic [127:0] i_accum_bit;
    logic [31:0]  i_data_ram_for_read;
    logic [31:0]  o_regf_to_gpio;
    logic         o_rst_soft;
    logic         o_en_rx_soft;
    logic [15:0]  o_sigma;
    logic [2:0]   o_data_sel_for_log;
    logic         o_en_write;
    logic         o_en_read_from_ram;
    logic [14:0]  o_read_adrs;

    int total;
    int bad;

    gpio_cmd_regfile_mc dut (
        .clk                 (clk),
        .i_reset             (i_reset),
        .i_gpio_to_regf      (i_gpio_to_regf),
        .i_accum_err         (i_accum_err),
        .i_accum_bit         (i_accum_bit),
        .i_data_ram_for_read (i_data_ram_for_read),
        .o_regf_to_gpio      (o_regf_to_gpio),
        .o_rst_soft          (o_rst_soft),
        .o_en_rx_soft        (o_en_rx_soft),
        .o_sigma             (o_sigma),
        .o_data_sel_for_log  (o_data_sel_for_log),
        .o_en_write          (o_en_write),
        .o_en_read_from_ram  (o_en_read_from_ram),
        .o_read_adrs         (o_read_adrs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse the strobe for one cycle, then drop it so readback reflects the command
    task automatic send(input logic [31:0] cmd);
        i_gpio_to_regf = cmd;
        tick();
        i_gpio_to_regf = '0;
        tick();
    endtask

    // Count consecutive cycles with o_rst_soft high, bounded
    task automatic count_pulse(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!o_rst_soft) break;
            n++;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rst_soft"}, o_rst_soft, 1'b1);
        check({tag, "_en_rx"}, o_en_rx_soft, 1'b1);
        check({tag, "_sigma"}, o_sigma, 16'h1C1C);
        check({tag, "_en_write"}, o_en_write, 1'b0);
        check({tag, "_sel_log"}, o_data_sel_for_log, 3'd0);
        check({tag, "_en_read"}, o_en_read_from_ram, 1'b0);
        check({tag, "_adrs"}, o_read_adrs, 15'd0);
        check({tag, "_readback"}, o_regf_to_gpio, 32'd0);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        i_reset             = 1'b1;
        i_gpio_to_regf      = '0;
        i_accum_err         = '0;
        i_accum_bit         = '0;
        i_data_ram_for_read = '0;
        repeat (3) tick();
        check_reset_vals("reset");

        // Soft-reset pulse after release
        i_reset = 1'b0;
        count_pulse(n);
        check("release_pulse_len", n, 16);

        // Held strobe executes once; sigma[1] = 5 one cycle after first strobe
        i_gpio_to_regf = 32'h0381_0005;
        tick();
        check("sigma_after_1cyc", o_sigma, 16'h051C);
        repeat (9) tick();
        i_gpio_to_regf = '0;
        tick();
        check("sigma_held", o_sigma, 16'h051C);
        send(32'h0385_0009);                  // ch 5: invalid
        check("sigma_bad_ch", o_sigma, 16'h051C);
        send(32'h0880_0000);                  // cmd 3
        check("status_err_ch", o_regf_to_gpio, 32'h0003_0801);

        // Unknown opcode, then sticky clear
        send(32'h5580_0000);                  // cmd 4
        send(32'h0880_0000);                  // cmd 5
        check("status_err_op", o_regf_to_gpio, 32'h0005_0805);
        send(32'h0880_0001);                  // cmd 6
        check("status_clear", o_regf_to_gpio, 32'h0006_0800);

        // Atomic snapshot and word-indexed readback
        i_accum_err = {64'h0000_0002_0000_0003, 64'h1111_2222_3333_4444};
        i_accum_bit = {64'hAAAA_BBBB_CCCC_DDDD, 64'h5555_6666_7777_8888};
        send(32'h0680_0001);                  // cmd 7
        i_accum_err = '1;
        i_accum_bit = '1;
        send(32'h0780_0011);                  // cmd 8
        check("cnt_ch1_err_w1", o_regf_to_gpio, 32'h0000_0002);
        send(32'h0780_0010);                  // cmd 9
        check("cnt_ch1_err_w0", o_regf_to_gpio, 32'h0000_0003);
        send(32'h0780_0019);                  // cmd 10
        check("cnt_ch1_bit_w1", o_regf_to_gpio, 32'hAAAA_BBBB);
        send(32'h0780_0000);                  // cmd 11
        check("cnt_ch0_err_w0", o_regf_to_gpio, 32'h3333_4444);
        send(32'h0780_0020);                  // cmd 12
        check("cnt_bad_ch", o_regf_to_gpio, 32'h0);
        send(32'h0780_0012);                  // cmd 13
        check("cnt_bad_word", o_regf_to_gpio, 32'h0);
        send(32'h0880_0000);                  // cmd 14
        check("status_err_sel", o_regf_to_gpio, 32'h000E_0802);
        send(32'h0680_0000);                  // cmd 15: payload[0]=0, no snapshot
        send(32'h0780_0011);                  // cmd 16
        check("no_snap_p0", o_regf_to_gpio, 32'h0000_0002);

        // RAM readback
        send(32'h0581_1234);                  // cmd 17
        check("ram_adrs", o_read_adrs, 15'h1234);
        check("ram_en_read", o_en_read_from_ram, 1'b1);
        i_data_ram_for_read = 32'hDEAD_BEEF;
        tick();
        check("ram_data1", o_regf_to_gpio, 32'hDEAD_BEEF);
        i_data_ram_for_read = 32'hCAFE_0001;
        #2;
        check("ram_latency", o_regf_to_gpio, 32'hDEAD_BEEF);
        tick();
        check("ram_data2", o_regf_to_gpio, 32'hCAFE_0001);
        send(32'h0580_0000);                  // cmd 18
        check("ram_off_rb", o_regf_to_gpio, 32'h0);
        check("ram_off_en", o_en_read_from_ram, 1'b0);
        check("ram_off_adrs", o_read_adrs, 15'h0);

        // RX enable and logging controls
        send(32'h0280_0000);
        check("en_rx_off", o_en_rx_soft, 1'b0);
        send(32'h0480_000D);
        check("log_sel", o_data_sel_for_log, 3'd5);
        check("log_en_write", o_en_write, 1'b1);

        // 0x01 with payload[0]=0 has no effect
        send(32'h0180_0000);
        check("pulse_p0", o_rst_soft, 1'b0);

        // Pulse re-issued at pulse cycle 8 restarts the full length
        i_gpio_to_regf = 32'h0180_0001;
        tick();
        i_gpio_to_regf = '0;
        repeat (7) tick();
        check("pulse_mid", o_rst_soft, 1'b1);
        i_gpio_to_regf = 32'h0180_0001;
        tick();
        i_gpio_to_regf = '0;
        count_pulse(n);
        check("pulse_reissue_len", n, 16);

        // Reset mid-pulse wins
        i_gpio_to_regf = 32'h0180_0001;
        tick();
        i_gpio_to_regf = '0;
        repeat (3) tick();
        i_reset = 1'b1;
        tick();
        check_reset_vals("midreset");
        i_reset = 1'b0;
        count_pulse(n);
        check("midreset_pulse_len", n, 16);
        send(32'h0880_0000);
        check("midreset_status", o_regf_to_gpio, 32'h0001_0800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
